// File: rtl/logic_unit_arbiter_if.sv
// Handshake bundle between the two issue ports, the arbiter and the result consumer.
interface logic_unit_arbiter_if #(parameter int WIDTH = 32);
  logic             req0_valid, req0_ready;
  logic [1:0]       req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [1:0]       req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             resp_valid, resp_ready, resp_id;
  logic [WIDTH-1:0] resp_data;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  resp_ready,
    output req0_ready, req1_ready, resp_valid, resp_id, resp_data
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output resp_ready,
    input  req0_ready, req1_ready, resp_valid, resp_id, resp_data
  );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter and IDLE/EXEC/RESP sequencer in front of one shared
// 32-bit bitwise unit; one operation in flight, tagged response with backpressure.
module logic_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  logic_unit_arbiter_if.slave  bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

  state_t           state, state_nxt;
  req_t [1:0]       req;
  req_t             cap;
  logic [1:0]       vld, gnt;
  logic             win, last_grant, cap_id;
  logic             resp_id_q;
  logic [WIDTH-1:0] resp_data_q;

  function automatic logic [WIDTH-1:0] lu(input req_t r);
    case (r.op)
      2'b00:   lu = r.a & r.b;
      2'b01:   lu = r.a | r.b;
      2'b10:   lu = r.a ^ r.b;
      default: lu = ~(r.a | r.b);
    endcase
  endfunction

  assign vld    = {bus.req1_valid, bus.req0_valid};
  assign req[0] = {bus.req0_op, bus.req0_a, bus.req0_b};
  assign req[1] = {bus.req1_op, bus.req1_a, bus.req1_b};

  always_comb begin
    state_nxt = state;
    gnt       = 2'b00;
    win       = 1'b0;
    case (state)
      IDLE: if (|vld) begin
        // on a tie the requester not served last wins
        win       = (&vld) ? ~last_grant : vld[1];
        gnt       = win ? 2'b10 : 2'b01;
        state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      cap         <= '0;
      cap_id      <= 1'b0;
      resp_data_q <= '0;
      resp_id_q   <= 1'b0;
      op_count    <= '0;
    end else begin
      state <= state_nxt;
      if (|gnt) begin
        last_grant <= win;
        cap        <= req[win];
        cap_id     <= win;
      end
      if (state == EXEC) begin
        resp_data_q <= lu(cap);
        resp_id_q   <= cap_id;
      end
      if (state == RESP && bus.resp_ready) op_count <= op_count + CNT_W'(1);
    end
  end

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_id    = resp_id_q;
  assign busy           = (state != IDLE);
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter; a second CNT_W=2 instance mirrors the
// same stimulus to observe counter wrap.
module tb_logic_unit_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy, busy2;
  logic [15:0] op_count;
  logic [1:0]  op_count2;
  int          errors = 0;
  int          checks = 0;
  int          exp_cnt = 0;

  logic_unit_arbiter_if #(.WIDTH(32)) bus ();
  logic_unit_arbiter_if #(.WIDTH(32)) bus2 ();

  assign bus2.req0_valid = bus.req0_valid;
  assign bus2.req0_op    = bus.req0_op;
  assign bus2.req0_a     = bus.req0_a;
  assign bus2.req0_b     = bus.req0_b;
  assign bus2.req1_valid = bus.req1_valid;
  assign bus2.req1_op    = bus.req1_op;
  assign bus2.req1_a     = bus.req1_a;
  assign bus2.req1_b     = bus.req1_b;
  assign bus2.resp_ready = bus.resp_ready;

  logic_unit_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave), .busy(busy), .op_count(op_count));

  logic_unit_arbiter #(.WIDTH(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave), .busy(busy2), .op_count(op_count2));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issue one op from requester id and collect its response; lat counts cycles from grant edge to resp_valid.
  task automatic single_op(input logic id, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] data, output logic rid, output int lat);
    int n = 0;
    if (id) begin bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b; end
    else    begin bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b; end
    #1;
    while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin @(posedge clk); #1; n++; end
    checks++;
    if (n >= 20) begin $display("FAIL grant_timeout: got no ready, want ready within 20 cycles"); errors++; end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    data = bus.resp_data;
    rid  = bus.resp_id;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
    bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
    bus.resp_ready = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks += 7;
    if (bus.resp_valid !== 1'b0) begin $display("FAIL rst_resp_valid: got %b want 0", bus.resp_valid); errors++; end
    if (bus.resp_id !== 1'b0) begin $display("FAIL rst_resp_id: got %b want 0", bus.resp_id); errors++; end
    if (bus.resp_data !== 32'h0) begin $display("FAIL rst_resp_data: got %h want 0", bus.resp_data); errors++; end
    if (busy !== 1'b0) begin $display("FAIL rst_busy: got %b want 0", busy); errors++; end
    if (op_count !== 16'h0) begin $display("FAIL rst_op_count: got %0d want 0", op_count); errors++; end
    if (bus.req0_ready !== 1'b0) begin $display("FAIL rst_req0_ready: got %b want 0", bus.req0_ready); errors++; end
    if (bus.req1_ready !== 1'b0) begin $display("FAIL rst_req1_ready: got %b want 0", bus.req1_ready); errors++; end
  endtask

  task automatic test_and();
    logic [31:0] d; logic r; int l;
    bus.resp_ready = 1'b1;
    single_op(1'b0, 2'b00, 32'hCCCCCCCC, 32'hAAAAAAAA, d, r, l);
    exp_cnt++;
    checks += 4;
    if (d !== 32'h88888888) begin $display("FAIL and_data: got %h want 88888888", d); errors++; end
    if (r !== 1'b0) begin $display("FAIL and_id: got %b want 0", r); errors++; end
    if (l !== 2) begin $display("FAIL and_latency: got %0d want 2", l); errors++; end
    if (op_count !== 16'(exp_cnt)) begin $display("FAIL and_op_count: got %0d want %0d", op_count, exp_cnt); errors++; end
  endtask

  task automatic test_req1_ops();
    logic [1:0]  ops [4] = '{2'b01, 2'b10, 2'b11, 2'b11};
    logic [31:0] av  [4] = '{32'hCCCCCCCC, 32'hCCCCCCCC, 32'hCCCCCCCC, 32'h0};
    logic [31:0] bv  [4] = '{32'hAAAAAAAA, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0};
    logic [31:0] ev  [4] = '{32'hEEEEEEEE, 32'h66666666, 32'h11111111, 32'hFFFFFFFF};
    logic [31:0] d; logic r; int l;
    for (int i = 0; i < 4; i++) begin
      single_op(1'b1, ops[i], av[i], bv[i], d, r, l);
      exp_cnt++;
      checks += 2;
      if (d !== ev[i]) begin $display("FAIL req1_op%0d_data: got %h want %h", i, d, ev[i]); errors++; end
      if (r !== 1'b1) begin $display("FAIL req1_op%0d_id: got %b want 1", i, r); errors++; end
    end
    checks++;
    if (op_count !== 16'(exp_cnt)) begin $display("FAIL req1_op_count: got %0d want %0d", op_count, exp_cnt); errors++; end
  endtask

  task automatic test_round_robin();
    logic        gseq [4];
    logic        rseq [4];
    logic [31:0] rdat [4];
    logic [31:0] edat [2] = '{32'hF0F00000, 32'h00FFFFFF};
    int g = 0, r = 0, cyc = 0;
    logic both = 1'b0;
    bus.req0_valid = 1; bus.req0_op = 2'b00; bus.req0_a = 32'hFFFF0000; bus.req0_b = 32'hF0F0F0F0;
    bus.req1_valid = 1; bus.req1_op = 2'b01; bus.req1_a = 32'h0000FFFF; bus.req1_b = 32'h00FF00FF;
    bus.resp_ready = 1;
    #1;
    while (r < 4 && cyc < 60) begin
      if (bus.req0_ready && bus.req1_ready) both = 1'b1;
      if ((bus.req0_ready || bus.req1_ready) && g < 4) begin gseq[g] = bus.req1_ready; g++; end
      if (bus.resp_valid) begin
        rseq[r] = bus.resp_id; rdat[r] = bus.resp_data; r++;
        if (r == 4) begin bus.req0_valid = 0; bus.req1_valid = 0; end
      end
      @(posedge clk); #1; cyc++;
    end
    exp_cnt += 4;
    checks += 3;
    if (r !== 4) begin $display("FAIL rr_responses: got %0d want 4", r); errors++; end
    if (g !== 4) begin $display("FAIL rr_grants: got %0d want 4", g); errors++; end
    if (both !== 1'b0) begin $display("FAIL rr_both_ready: got %b want 0", both); errors++; end
    for (int i = 0; i < 4 && i < r && i < g; i++) begin
      checks += 3;
      if (gseq[i] !== 1'(i % 2)) begin $display("FAIL rr_grant%0d: got %b want %0d", i, gseq[i], i % 2); errors++; end
      if (rseq[i] !== 1'(i % 2)) begin $display("FAIL rr_id%0d: got %b want %0d", i, rseq[i], i % 2); errors++; end
      if (rdat[i] !== edat[i % 2]) begin $display("FAIL rr_data%0d: got %h want %h", i, rdat[i], edat[i % 2]); errors++; end
    end
    checks++;
    if (op_count !== 16'(exp_cnt)) begin $display("FAIL rr_op_count: got %0d want %0d", op_count, exp_cnt); errors++; end
  endtask

  task automatic test_backpressure();
    bus.resp_ready = 0;
    bus.req0_valid = 1; bus.req0_op = 2'b10; bus.req0_a = 32'h12345678; bus.req0_b = 32'hFFFF0000;
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin $display("FAIL bp_grant: got %b want 1", bus.req0_ready); errors++; end
    @(posedge clk); #1;
    bus.req0_valid = 0; bus.req0_op = 2'b00; bus.req0_a = 32'h0; bus.req0_b = 32'h0;
    bus.req1_valid = 1; bus.req1_op = 2'b00; bus.req1_a = 32'hFFFF0000; bus.req1_b = 32'h0F0F0F0F;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks += 4;
      if (bus.resp_valid !== 1'b1) begin $display("FAIL bp_valid%0d: got %b want 1", i, bus.resp_valid); errors++; end
      if (bus.resp_data !== 32'hEDCB5678) begin $display("FAIL bp_data%0d: got %h want edcb5678", i, bus.resp_data); errors++; end
      if (bus.resp_id !== 1'b0) begin $display("FAIL bp_id%0d: got %b want 0", i, bus.resp_id); errors++; end
      if (bus.req0_ready | bus.req1_ready) begin $display("FAIL bp_ready%0d: got %b%b want 00", i, bus.req1_ready, bus.req0_ready); errors++; end
      bus.req1_a = bus.req1_a ^ 32'h0000_0001;
      bus.req1_a = bus.req1_a ^ 32'h0000_0001;
      @(posedge clk); #1;
    end
    bus.resp_ready = 1;
    @(posedge clk); #1;
    exp_cnt++;
    checks += 4;
    if (bus.req1_ready !== 1'b1) begin $display("FAIL bp_next_grant: got %b want 1", bus.req1_ready); errors++; end
    if (bus.req0_ready !== 1'b0) begin $display("FAIL bp_next_r0: got %b want 0", bus.req0_ready); errors++; end
    if (bus.resp_valid !== 1'b0) begin $display("FAIL bp_after_hs: got %b want 0", bus.resp_valid); errors++; end
    if (op_count !== 16'(exp_cnt)) begin $display("FAIL bp_op_count: got %0d want %0d", op_count, exp_cnt); errors++; end
    @(posedge clk); #1;
    bus.req1_valid = 0;
    @(posedge clk); #1;
    checks += 2;
    if (bus.resp_data !== 32'h0F0F0000) begin $display("FAIL bp_req1_data: got %h want 0f0f0000", bus.resp_data); errors++; end
    if (bus.resp_id !== 1'b1) begin $display("FAIL bp_req1_id: got %b want 1", bus.resp_id); errors++; end
    @(posedge clk); #1;
    exp_cnt++;
  endtask

  task automatic test_reset_mid_op();
    bus.resp_ready = 1;
    bus.req0_valid = 1; bus.req0_op = 2'b00; bus.req0_a = 32'hFFFFFFFF; bus.req0_b = 32'hFFFFFFFF;
    #1;
    @(posedge clk); #1;
    bus.req0_valid = 0;
    checks++;
    if (busy !== 1'b1) begin $display("FAIL mid_busy_exec: got %b want 1", busy); errors++; end
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    checks += 4;
    if (busy !== 1'b0) begin $display("FAIL mid_busy: got %b want 0", busy); errors++; end
    if (bus.resp_valid !== 1'b0) begin $display("FAIL mid_valid: got %b want 0", bus.resp_valid); errors++; end
    if (bus.resp_data !== 32'h0) begin $display("FAIL mid_data: got %h want 0", bus.resp_data); errors++; end
    if (op_count !== 16'h0) begin $display("FAIL mid_op_count: got %0d want 0", op_count); errors++; end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.resp_valid !== 1'b0) begin $display("FAIL mid_no_resp%0d: got %b want 0", i, bus.resp_valid); errors++; end
    end
    bus.req0_valid = 1; bus.req0_op = 2'b10; bus.req0_a = 32'hAAAAAAAA; bus.req0_b = 32'h0;
    bus.req1_valid = 1; bus.req1_op = 2'b01; bus.req1_a = 32'h1;        bus.req1_b = 32'h2;
    #1;
    checks += 2;
    if (bus.req0_ready !== 1'b1) begin $display("FAIL mid_tie_r0: got %b want 1", bus.req0_ready); errors++; end
    if (bus.req1_ready !== 1'b0) begin $display("FAIL mid_tie_r1: got %b want 0", bus.req1_ready); errors++; end
    @(posedge clk); #1;
    bus.req0_valid = 0; bus.req1_valid = 0;
    @(posedge clk); #1;
    checks += 2;
    if (bus.resp_id !== 1'b0) begin $display("FAIL mid_tie_id: got %b want 0", bus.resp_id); errors++; end
    if (bus.resp_data !== 32'hAAAAAAAA) begin $display("FAIL mid_tie_data: got %h want aaaaaaaa", bus.resp_data); errors++; end
    @(posedge clk); #1;
    exp_cnt++;
    checks++;
    if (op_count !== 16'(exp_cnt)) begin $display("FAIL mid_op_count_after: got %0d want %0d", op_count, exp_cnt); errors++; end
  endtask

  task automatic test_count_wrap();
    logic [1:0]  ew [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [31:0] d; logic r; int l;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    exp_cnt = 0;
    bus.resp_ready = 1;
    for (int i = 0; i < 5; i++) begin
      single_op(1'(i % 2), 2'b10, 32'(i), 32'h5, d, r, l);
      exp_cnt++;
      checks += 3;
      if (op_count2 !== ew[i]) begin $display("FAIL wrap_count%0d: got %0d want %0d", i, op_count2, ew[i]); errors++; end
      if (op_count !== 16'(exp_cnt)) begin $display("FAIL wrap_wide%0d: got %0d want %0d", i, op_count, exp_cnt); errors++; end
      if (d !== (32'(i) ^ 32'h5)) begin $display("FAIL wrap_data%0d: got %h want %h", i, d, 32'(i) ^ 32'h5); errors++; end
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_req1_ops();
    test_round_robin();
    test_backpressure();
    test_reset_mid_op();
    test_count_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Two-requester arbiter and sequencer for the shared 32-bit bitwise logic unit (AND/OR/XOR/NOR). It accepts one operation at a time from either requester through a valid/ready handshake and alternates priority round-robin. It computes and registers the result, then returns it on a single tagged response port with backpressure. It sits between the register-file read stage and the shared logic datapath, so both issue ports can use one bitwise unit.

## Interface
- WIDTH, 32, operand/result width
- CNT_W, 16, width of completed-operation counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_op  in  2  00 AND, 01 OR, 10 XOR, 11 NOR
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req1_valid, req1_ready, req1_op, req1_a, req1_b  same as requester 0, for requester 1
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_id  out  1  requester that issued the result
- resp_data  out  WIDTH  result
- busy  out  1  FSM not in IDLE
- op_count  out  CNT_W  completed responses, wraps

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE, no reqN_valid: stay in IDLE.
- IDLE, any reqN_valid: grant one requester and go to EXEC.
- Grant and capture: assert that requester's reqN_ready combinationally, and latch op, a, b and id.
- EXEC: compute the latched op and register it into resp_data. Always exactly 1 cycle, then go to RESP.
- RESP: hold resp_valid=1 with resp_data and resp_id stable until resp_valid & resp_ready. On that handshake go to IDLE and increment op_count.
- Ops: AND a&b; OR a|b; XOR a^b; NOR ~(a|b). Full WIDTH, no carries, no flags.
- Arbitration:
  - Only one valid: that requester wins.
  - Both valid: the requester not granted last wins.
  - last_grant resets to 1, so requester 0 wins the first tie.
  - last_grant updates only on grant.
- reqN_ready is 0 outside IDLE and for the losing requester. At most one ready is high per cycle.
- Operands sampled only at the granting edge. Later changes to reqN_a/b/op do not affect the in-flight result.
- A requester dropping valid before being granted is legal. Nothing is captured.
- op_count wraps from 2^CNT_W-1 to 0.

## Timing
- Reset (async assert, sync release), all registers cleared:
  - state=IDLE
  - resp_valid=0, resp_id=0, resp_data=0
  - busy=0, op_count=0
  - req0_ready=0, req1_ready=0 (combinational, from IDLE with no valid)
  - last_grant=1
- Reset mid-operation: the in-flight operation is discarded with no response and op_count is not incremented.
- Latency: with grant at edge E (IDLE cycle with ready=1), EXEC is the cycle after E and resp_valid rises 2 cycles after E.
- Throughput: with resp_ready held 1, one operation per 3 cycles (IDLE, EXEC, RESP).
- Requests in EXEC/RESP wait. Waiting requests are granted in the first IDLE cycle after the response handshake.
- busy=1 in EXEC and RESP.

## Test plan
- Reset, then req0 AND a=0xCCCCCCCC b=0xAAAAAAAA, resp_ready=1 -> resp_data=0x88888888, resp_id=0, resp_valid 2 cycles after grant, op_count=1.
- req1 OR, XOR, NOR on the same operands, then NOR a=0 b=0 -> 0xEEEEEEEE, 0x66666666, 0x11111111, 0xFFFFFFFF; resp_id=1 on all four.
- Both requesters continuously valid for 4 ops -> grant order and resp_id sequence 0,1,0,1; never both readies high.
- Backpressure: resp_ready=0 for 5 cycles in RESP, operands changed meanwhile -> resp_valid, resp_data and resp_id stay stable, no new ready. When resp_ready=1 -> handshake, then the next grant in the following IDLE cycle.
- rst_n pulsed low during EXEC -> all outputs return to reset values immediately, no response, op_count=0; the next tie grants requester 0.
- op_count with CNT_W=2: 5 completed ops -> op_count sequence 1,2,3,0,1.
